// File: rtl/cook_timer_pkg.sv
// cook_timer_pkg
//   Shared types and constants for the microwave cook timer.
//   - cook_state_t : controller state encoding
//   - QS_*         : time loaded by the quick-start feature (0:30)
//   - BCD_*        : largest legal value of each digit position
package cook_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } cook_state_t;

    localparam logic [3:0] QS_MIN    = 4'd0;
    localparam logic [3:0] QS_SEC_T  = 4'd3;
    localparam logic [3:0] QS_SEC_ON = 4'd0;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;  // minutes / units of seconds
    localparam logic [3:0] BCD_MAX_TENS  = 4'd5;  // tens of seconds

endpackage

// File: rtl/bcd_time_reg.sv
// bcd_time_reg
//   Three-digit M:SS BCD time register.
//   Operations, in priority order: clear, parallel load, shift-in of one
//   digit from the right, decrement by one second with BCD borrow.
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     clr                           clear all digits to 0:00
//     load, load_min/sec_t/sec_on   parallel load of all three digits
//     shift, shift_digit            min<-sec_t, sec_t<-sec_on, sec_on<-digit
//     dec                           count down one second (no-op at 0:00)
//     min, sec_t, sec_on            current digits
//     zero                          time is 0:00
//     is_one                        time is 0:01 (next decrement reaches zero)
module bcd_time_reg
    import cook_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_min,
    input  logic [3:0] load_sec_t,
    input  logic [3:0] load_sec_on,
    input  logic       shift,
    input  logic [3:0] shift_digit,
    input  logic       dec,
    output logic [3:0] min,
    output logic [3:0] sec_t,
    output logic [3:0] sec_on,
    output logic       zero,
    output logic       is_one
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            min    <= 4'd0;
            sec_t  <= 4'd0;
            sec_on <= 4'd0;
        end else if (load) begin
            min    <= load_min;
            sec_t  <= load_sec_t;
            sec_on <= load_sec_on;
        end else if (shift) begin
            min    <= sec_t;
            sec_t  <= sec_on;
            sec_on <= shift_digit;
        end else if (dec && !zero) begin
            // Borrow ripples units -> tens -> minutes; guarded by !zero so
            // minutes can never wrap below 0.
            if (sec_on != 4'd0) begin
                sec_on <= sec_on - 4'd1;
            end else begin
                sec_on <= BCD_MAX_DIGIT;
                if (sec_t != 4'd0) begin
                    sec_t <= sec_t - 4'd1;
                end else begin
                    sec_t <= BCD_MAX_TENS;
                    min   <= min - 4'd1;
                end
            end
        end
    end

    assign zero   = (min == 4'd0) && (sec_t == 4'd0) && (sec_on == 4'd0);
    assign is_one = (min == 4'd0) && (sec_t == 4'd0) && (sec_on == 4'd1);

endmodule

// File: rtl/cook_timer_ctrl.sv
// cook_timer_ctrl
//   Microwave cook timer sequencer: keypad entry into an M:SS BCD register,
//   1 Hz countdown from a TICK_DIV-cycle prescaler, door interlock on the
//   magnetron enable and a sticky completion flag.
//   Build option: define COOK_QUICK_START_EN so that start at 0:00 loads
//   0:30 and begins cooking; otherwise start at 0:00 is ignored.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     key_valid, key_digit      keypad strobe and BCD digit (10-15 ignored)
//     start, stop_clear         one-cycle command strobes
//     door_closed               interlock level, 1 = closed
//     min, sec_t, sec_on        displayed time digits
//     mag_on                    magnetron enable
//     done                      cooking finished, held until cleared
//     busy                      state is RUN or PAUSE
module cook_timer_ctrl
    import cook_timer_pkg::*;
#(
    parameter int TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    output logic [3:0] min,
    output logic [3:0] sec_t,
    output logic [3:0] sec_on,
    output logic       mag_on,
    output logic       done,
    output logic       busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    cook_state_t   state, state_n;
    logic [PW-1:0] presc, presc_n;

    logic t_clr, t_load, t_shift, t_dec;
    logic t_zero, t_is_one;
    logic key_ok;

    bcd_time_reg u_time (
        .clk         (clk),
        .rst         (rst),
        .clr         (t_clr),
        .load        (t_load),
        .load_min    (QS_MIN),
        .load_sec_t  (QS_SEC_T),
        .load_sec_on (QS_SEC_ON),
        .shift       (t_shift),
        .shift_digit (key_digit),
        .dec         (t_dec),
        .min         (min),
        .sec_t       (sec_t),
        .sec_on      (sec_on),
        .zero        (t_zero),
        .is_one      (t_is_one)
    );

    // A key is taken only if it is a digit, entry is not yet full, and the
    // digit moving into the tens-of-seconds slot would still be 0-5.
    assign key_ok = (key_digit <= BCD_MAX_DIGIT) && (min == 4'd0) &&
                    (sec_on <= BCD_MAX_TENS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            presc <= '0;
        end else begin
            state <= state_n;
            presc <= presc_n;
        end
    end

    // Branch order inside each state encodes the input priority:
    // stop_clear, then door open, then start, then keys.
    always_comb begin
        state_n = state;
        presc_n = presc;
        t_clr   = 1'b0;
        t_load  = 1'b0;
        t_shift = 1'b0;
        t_dec   = 1'b0;
        unique case (state)
            IDLE: begin
                if (stop_clear) begin
                    t_clr = 1'b1;
                end else if (start) begin
                    if (door_closed) begin
                        if (!t_zero) begin
                            state_n = RUN;
                            presc_n = '0;
                        end else begin
`ifdef COOK_QUICK_START_EN
                            t_load  = 1'b1;
                            state_n = RUN;
                            presc_n = '0;
`endif
                        end
                    end
                end else if (key_valid && key_ok) begin
                    t_shift = 1'b1;
                end
            end
            RUN: begin
                // Pause leaves presc untouched so a resume continues the
                // partially counted second; a tick landing here is dropped.
                if (stop_clear || !door_closed) begin
                    state_n = PAUSE;
                end else if (presc == PRESC_LAST) begin
                    presc_n = '0;
                    t_dec   = 1'b1;
                    if (t_is_one) state_n = DONE;
                end else begin
                    presc_n = presc + PW'(1);
                end
            end
            PAUSE: begin
                if (stop_clear) begin
                    state_n = IDLE;
                    t_clr   = 1'b1;
                    presc_n = '0;
                end else if (start && door_closed) begin
                    state_n = RUN;
                end
            end
            DONE: begin
                if (stop_clear || !door_closed) begin
                    state_n = IDLE;
                    t_clr   = 1'b1;
                    presc_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Combinational from the registered state so the interlock acts in the
    // same cycle the door opens.
    assign mag_on = (state == RUN) && door_closed;
    assign done   = (state == DONE);
    assign busy   = (state == RUN) || (state == PAUSE);

endmodule

// File: tb/tb_cook_timer_ctrl.sv
module tb_cook_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       stop_clear = 1'b0;
    logic       door_closed = 1'b1;
    logic [3:0] min, sec_t, sec_on;
    logic       mag_on, done, busy;

    int checks = 0;
    int errors = 0;

    cook_timer_ctrl #(.TICK_DIV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .start       (start),
        .stop_clear  (stop_clear),
        .door_closed (door_closed),
        .min         (min),
        .sec_t       (sec_t),
        .sec_on      (sec_on),
        .mag_on      (mag_on),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_clear = 1'b1;
        tick();
        stop_clear = 1'b0;
    endtask

    // time as 12'hMST, flags as {mag_on, done, busy}
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input logic [11:0] exp);
        chk(tag, {4'h0, min, sec_t, sec_on}, {4'h0, exp});
    endtask

    task automatic chk_flags(input string tag, input logic [2:0] exp);
        chk(tag, {13'h0, mag_on, done, busy}, {13'h0, exp});
    endtask

    initial begin
        // Reset
        ticks(2);
        rst = 1'b0;
        chk_time("reset_time", 12'h000);
        chk_flags("reset_flags", 3'b000);

        // Entry 1,3,0 -> 1:30, full countdown
        key(4'd1);
        chk_time("key_1", 12'h001);
        key(4'd3);
        key(4'd0);
        chk_time("key_130", 12'h130);
        pulse_start();
        chk_flags("start_mag_on", 3'b101);
        ticks(3);
        chk_time("before_first_dec", 12'h130);
        tick();
        chk_time("first_dec", 12'h129);
        ticks(355);
        chk_time("at_0_01", 12'h001);
        chk_flags("at_0_01_flags", 3'b101);
        tick();
        chk_time("at_0_00", 12'h000);
        chk_flags("done_flags", 3'b010);
        pulse_start();
        chk_flags("start_in_done_ignored", 3'b010);
        pulse_stop();
        chk_flags("done_cleared", 3'b000);

        // Key rejection rules
        key(4'd12);
        chk_time("key_gt9_ignored", 12'h000);
        key(4'd7);
        key(4'd8);
        chk_time("key_sec_on_gt5", 12'h007);
        pulse_stop();
        chk_time("idle_clear", 12'h000);
        key(4'd1);
        key(4'd2);
        key(4'd3);
        key(4'd4);
        chk_time("key_entry_full", 12'h123);
        pulse_stop();

        // Door opened mid-prescaler, then resume
        key(4'd1);
        key(4'd0);
        pulse_start();
        ticks(2);
        door_closed = 1'b0;
        #1;
        chk_flags("door_open_comb", 3'b001);
        tick();
        ticks(3);
        chk_time("pause_holds_time", 12'h010);
        chk_flags("pause_flags", 3'b001);
        door_closed = 1'b1;
        #1;
        chk_flags("pause_door_closed_no_mag", 3'b001);
        pulse_start();
        chk_flags("resume_mag_on", 3'b101);
        tick();
        chk_time("resume_before_dec", 12'h010);
        tick();
        chk_time("resume_dec", 12'h009);

        // stop_clear beats start in RUN, then clear from PAUSE
        stop_clear = 1'b1;
        start = 1'b1;
        tick();
        stop_clear = 1'b0;
        start = 1'b0;
        chk_flags("stop_beats_start", 3'b001);
        pulse_stop();
        chk_time("pause_clear_time", 12'h000);
        chk_flags("pause_clear_flags", 3'b000);

        // Borrow from minutes; keys ignored while running
        key(4'd1);
        key(4'd0);
        key(4'd0);
        pulse_start();
        key(4'd5);
        ticks(2);
        chk_time("key_ignored_in_run", 12'h100);
        tick();
        chk_time("borrow_min", 12'h059);

        // Reset mid-run
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_time("rst_run_time", 12'h000);
        chk_flags("rst_run_flags", 3'b000);

        // Door opening in DONE clears
        key(4'd1);
        pulse_start();
        ticks(4);
        chk_flags("done_short", 3'b010);
        door_closed = 1'b0;
        tick();
        door_closed = 1'b1;
        chk_flags("door_clears_done", 3'b000);
        chk_time("door_clears_done_time", 12'h000);

        // Start at 0:00
        pulse_start();
`ifdef COOK_QUICK_START_EN
        chk_time("quick_start_time", 12'h030);
        chk_flags("quick_start_flags", 3'b101);
`else
        chk_time("zero_start_time", 12'h000);
        chk_flags("zero_start_flags", 3'b000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cook_timer_ctrl.md
# cook_timer_ctrl

Sequencing controller for the microwave cook timer. Accepts keypad digits into a three-digit M:SS BCD register, runs a 1 Hz countdown from a clock-cycle prescaler, enforces the door interlock on the magnetron enable, and signals completion. Its `min`, `sec_t` and `sec_on` outputs drive the seven-segment decoder directly. It is the sole owner of the displayed time.

## Interface
- `TICK_DIV`, default 100: clock cycles per one-second tick; legal range ≥ 2.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `key_valid`  in  1: one-cycle strobe; `key_digit` is valid.
- `key_digit`  in  4: BCD digit 0–9; values 10–15 are ignored.
- `start`  in  1: one-cycle strobe; start or resume.
- `stop_clear`  in  1: one-cycle strobe; pause or clear.
- `door_closed`  in  1: door interlock, 1 = closed; level, already synchronised.
- `min`  out  4: minutes digit, BCD 0–9.
- `sec_t`  out  4: tens-of-seconds digit, BCD 0–5.
- `sec_on`  out  4: units-of-seconds digit, BCD 0–9.
- `mag_on`  out  1: magnetron enable.
- `done`  out  1: cook complete; held until cleared.
- `busy`  out  1: state is RUN or PAUSE.

## Operation
- States: IDLE (entry), RUN, PAUSE, DONE. Reset leads to IDLE, with all digits 0, prescaler 0, and `mag_on`, `done`, `busy` at 0.
- Priority within one cycle is `stop_clear` > door-open > `start` > `key_valid`.
- **IDLE, `key_valid`:** shift left, so `min`←`sec_t`, `sec_t`←`sec_on`, `sec_on`←`key_digit`. The key is ignored if any of these hold:
  - `key_digit` > 9;
  - `min` ≠ 0 (entry is full);
  - `sec_on` > 5 (the shift would make `sec_t` invalid).
- Keys are ignored in RUN, PAUSE and DONE.
- **IDLE, `start`:**
  - With time ≠ 0:00 and `door_closed`: go to RUN and clear the prescaler.
  - Door open: ignored.
  - Time = 0:00: see Configuration.
- **RUN:**
  - Prescaler counts 0..`TICK_DIV`-1. At terminal count it wraps and the time decrements by one second in BCD:
    - `sec_on` 0 → 9 with a borrow from `sec_t`;
    - `sec_t` 0 → 5 with a borrow from `min`.
  - A decrement that reaches 0:00 moves the state to DONE on the same edge.
- **RUN, door opens** (`door_closed`=0): go to PAUSE. The prescaler holds its value, and a tick in the same cycle is discarded.
- **RUN, `stop_clear`:** go to PAUSE; the prescaler holds.
- **PAUSE:**
  - `start` with `door_closed`: go to RUN, resuming from the held prescaler value.
  - `stop_clear`: go to IDLE with digits and prescaler cleared.
- **DONE:** `stop_clear` or the door opening goes to IDLE with digits cleared. `start` is ignored.
- **IDLE, `stop_clear`:** clear digits.
- `mag_on` = (state == RUN) && `door_closed`. It is combinational from the registered state, so the interlock cuts the magnetron in the same cycle the door opens.
- `done` = (state == DONE). `busy` = (state == RUN || state == PAUSE).
- Prescaler width is $clog2(`TICK_DIV`). The time digits never leave their legal ranges.

## Timing
- Key strobe to updated digit outputs: 1 cycle (registered).
- `start` to `mag_on`=1: 1 cycle.
- First decrement: `TICK_DIV` cycles after the RUN entry edge; later decrements every `TICK_DIV` cycles spent in RUN. Cycles in PAUSE are not counted.
- 0:01 → 0:00: the digits show 0:00, `done`=1 and `mag_on`=0 all at the same edge.
- Door open: `mag_on`=0 in the same cycle (combinational); state is PAUSE at the next edge.
- `rst` mid-run: IDLE at the next edge, and `mag_on` deasserts on that edge.

## Configuration
- `COOK_QUICK_START_EN` defined: `start` in IDLE with time 0:00 and `door_closed` loads 0:30 and enters RUN at the same edge.
- Not defined: `start` at 0:00 is ignored and the state stays IDLE.

## Structure
- Package `cook_timer_pkg` holds:
  - state enum `cook_state_t` (IDLE, RUN, PAUSE, DONE);
  - quick-start constants `QS_MIN`=0, `QS_SEC_T`=3, `QS_SEC_ON`=0;
  - BCD limits 9 and 5.
- One sub-module, `bcd_time_reg`: three-digit register with clear, load, shift-in and decrement-with-borrow, plus a `zero` and `is_one` flag. The FSM and prescaler live in `cook_timer_ctrl`.

## Test plan
All scenarios use `TICK_DIV`=4.
- Keys 1,3,0 then `start`, door closed: digits show 1:30; `mag_on`=1 one cycle after `start`; after 4 cycles the display reads 1:29; after 90 ticks 0:00, `done`=1, `mag_on`=0.
- Keys 7 then 8: the 8 is rejected because `sec_on`=7 > 5; display stays 0:07. Keys 1,2,3,4: the 4 is rejected because `min`≠0; display stays 1:23.
- Run 0:10, open the door mid-prescaler at count 2: `mag_on`=0 the same cycle and the state becomes PAUSE. Close the door and `start`: the next decrement comes 2 cycles later.
- Borrow: run 1:00 for one tick → 0:59. Run 0:10 for one tick → 0:09.
- `stop_clear` and `start` in the same cycle while in RUN: goes to PAUSE. A second `stop_clear` goes to IDLE with 0:00. `rst` during RUN: IDLE and 0:00 at the next edge.
- `start` at 0:00: with `COOK_QUICK_START_EN`, loads 0:30 and `mag_on`=1; without it, stays IDLE with `mag_on`=0.
